// File: rtl/fx2_stream_tx.sv
// Moves words from a first-word-fall-through stream FIFO into the FX2 slave-FIFO IN endpoint.
// Short packets are committed with PKTEND after an idle timeout or when streaming is disabled.
module fx2_stream_tx #(
    parameter int         PACKET_WORDS  = 256,
    parameter int         FLUSH_TIMEOUT = 4096,
    parameter logic [1:0] EP_ADDR       = 2'b10
) (
    input  logic        STREAM_CLK,
    input  logic        STREAM_RST_N,
    input  logic        ENABLE,
    input  logic        FIFO_EMPTY_IN,
    input  logic [15:0] FIFO_DATA,
    output logic        FIFO_READ_NEXT_OUT,
    input  logic [2:0]  USB_STREAM_FLAGS_N,
    input  logic        USB_STREAM_FX2RDY,
    output logic [15:0] USB_STREAM_DATA,
    output logic        USB_STREAM_SLWR_n,
    output logic        USB_STREAM_PKTEND_N,
    output logic [1:0]  USB_STREAM_FIFOADDR,
    output logic        USB_STREAM_SLRD_n,
    output logic        USB_STREAM_SLOE_n,
    output logic [31:0] WORD_COUNT,
    output logic [15:0] PKTEND_COUNT
);

    localparam int          PW      = $clog2(PACKET_WORDS);
    localparam logic [15:0] TIMEOUT = 16'(FLUSH_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PKTEND = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] pkt_cnt;
    logic [15:0]   idle_cnt;
    logic          ready;
    logic          write;
    logic          unused_flags;

    assign unused_flags = ^{USB_STREAM_FLAGS_N[2], USB_STREAM_FLAGS_N[0]};

    assign USB_STREAM_FIFOADDR = EP_ADDR;
    assign USB_STREAM_SLRD_n   = 1'b1;
    assign USB_STREAM_SLOE_n   = 1'b1;

    // Only writes while enabled, so a disable never extends the packet being committed.
    assign ready              = USB_STREAM_FLAGS_N[1] & USB_STREAM_FX2RDY;
    assign write              = (state == S_RUN) & ENABLE & ready & ~FIFO_EMPTY_IN;
    assign FIFO_READ_NEXT_OUT = write;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (ENABLE) state_next = S_RUN;
            end
            S_RUN: begin
                // A pending word always beats a commit; a commit never closes an empty packet.
                if (write) begin
                    state_next = S_RUN;
                end else if (!ENABLE) begin
                    if (pkt_cnt == '0)  state_next = S_IDLE;
                    else if (ready)     state_next = S_PKTEND;
                end else if (idle_cnt == TIMEOUT && ready && pkt_cnt != '0) begin
                    state_next = S_PKTEND;
                end
            end
            S_PKTEND: begin
                state_next = S_GAP;
            end
            S_GAP: begin
                state_next = ENABLE ? S_RUN : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N) begin
            pkt_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            if (state == S_PKTEND)  pkt_cnt <= '0;
            else if (write)         pkt_cnt <= pkt_cnt + PW'(1);

            if (state == S_PKTEND || write || pkt_cnt == '0)
                idle_cnt <= '0;
            else if (state == S_RUN && idle_cnt != TIMEOUT)
                idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // PKTEND_N is registered from the next state so the strobe lines up with the PKTEND cycle.
    always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N) begin
            USB_STREAM_DATA     <= '0;
            USB_STREAM_SLWR_n   <= 1'b1;
            USB_STREAM_PKTEND_N <= 1'b1;
            WORD_COUNT          <= '0;
            PKTEND_COUNT        <= '0;
        end else begin
            USB_STREAM_SLWR_n   <= ~write;
            USB_STREAM_PKTEND_N <= ~(state_next == S_PKTEND);
            if (write) begin
                USB_STREAM_DATA <= FIFO_DATA;
                WORD_COUNT      <= WORD_COUNT + 32'd1;
            end
            if (state == S_PKTEND) PKTEND_COUNT <= PKTEND_COUNT + 16'd1;
        end
    end

endmodule

// File: tb/tb_fx2_stream_tx.sv
// Directed bench for fx2_stream_tx: FWFT FIFO model, pin monitor and expected-word queue.
module tb_fx2_stream_tx;

    localparam int FT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  flags_n = 3'b111;
    logic        fx2rdy = 1'b1;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_rd;
    logic [15:0] usb_data;
    logic        slwr_n, pktend_n, slrd_n, sloe_n;
    logic [1:0]  fifoaddr;
    logic [31:0] word_count;
    logic [15:0] pktend_count;

    always #5 clk = ~clk;

    fx2_stream_tx #(
        .PACKET_WORDS (256),
        .FLUSH_TIMEOUT(FT),
        .EP_ADDR      (2'b10)
    ) dut (
        .STREAM_CLK         (clk),
        .STREAM_RST_N       (rst_n),
        .ENABLE             (enable),
        .FIFO_EMPTY_IN      (fifo_empty),
        .FIFO_DATA          (fifo_data),
        .FIFO_READ_NEXT_OUT (fifo_rd),
        .USB_STREAM_FLAGS_N (flags_n),
        .USB_STREAM_FX2RDY  (fx2rdy),
        .USB_STREAM_DATA    (usb_data),
        .USB_STREAM_SLWR_n  (slwr_n),
        .USB_STREAM_PKTEND_N(pktend_n),
        .USB_STREAM_FIFOADDR(fifoaddr),
        .USB_STREAM_SLRD_n  (slrd_n),
        .USB_STREAM_SLOE_n  (sloe_n),
        .WORD_COUNT         (word_count),
        .PKTEND_COUNT       (pktend_count)
    );

    // Upstream FWFT FIFO model: bench fills fifo_mem, DUT pops via fifo_rd.
    logic [15:0] fifo_mem [2048];
    logic [10:0] wp = '0;
    logic [10:0] rp = '0;
    assign fifo_empty = (rp == wp);
    assign fifo_data  = fifo_mem[rp];
    always @(posedge clk) if (fifo_rd) rp <= rp + 11'd1;

    // Pin monitor, sampled just after each rising edge.
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc = 0;
    int          long_pulse = 0;
    int          viol = 0;
    logic        prev_pk = 1'b1;
    logic [15:0] obs_q[$];
    int          obs_cyc_q[$];
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!slwr_n) begin
            obs_q.push_back(usb_data);
            obs_cyc_q.push_back(cyc);
        end
        if (!pktend_n) begin
            pulse_cnt++;
            pulse_cyc = cyc;
            if (!prev_pk) long_pulse++;
        end
        prev_pk = pktend_n;
        if (fifo_rd && (!(flags_n[1] && fx2rdy) || fifo_empty)) viol++;
    end

    logic [15:0] exp_q[$];
    int          rd_i = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wp] = base + 16'(i);
            exp_q.push_back(base + 16'(i));
            wp = wp + 11'd1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_words(input string tag, input int target, input int budget);
        int k = 0;
        while (word_count != 32'(target) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, word_count, 32'(target));
    endtask

    task automatic wait_pulses(input string tag, input int target, input int budget);
        int k = 0;
        while (pulse_cnt != target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(pulse_cnt), 32'(target));
    endtask

    task automatic check_words(input string tag);
        check({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = rd_i; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, {16'h0, obs_q[i]}, {16'h0, exp_q[i]});
        rd_i = exp_q.size();
    endtask

    function automatic int last_write_cyc();
        return (obs_cyc_q.size() > 0) ? obs_cyc_q[obs_cyc_q.size()-1] : -1000;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cycles(3);
        check("rst_slwr", slwr_n, 1);
        check("rst_pktend", pktend_n, 1);
        check("rst_data", usb_data, 0);
        check("rst_rd", fifo_rd, 0);
        check("rst_wc", word_count, 0);
        check("rst_pc", pktend_count, 0);
        check("fifoaddr", fifoaddr, 2'b10);
        check("slrd_sloe", {slrd_n, sloe_n}, 2'b11);
        rst_n = 1'b1;

        // 512 preloaded words stream back to back.
        load(16'h0000, 512);
        cycles(4);
        check("idle_no_pop", word_count, 0);
        enable = 1'b1;
        wait_words("t1_wc", 512, 700);
        cycles(2);
        check_words("t1_data");
        check("t1_span", 32'(obs_cyc_q[511] - obs_cyc_q[0]), 511);
        check("t1_no_pulse", 32'(pulse_cnt), 0);

        // Five words then a forced commit; a word arriving at the pulse waits out the GAP.
        load(16'h0200, 5);
        wait_words("t2_wc", 517, 50);
        wait_pulses("t2_pulse", 1, 60);
        check("t2_delay", 32'(pulse_cyc - last_write_cyc()), 17);
        load(16'h0205, 1);
        wait_words("t2_wc2", 518, 10);
        check("t2_pc", pktend_count, 1);
        check("t2_gap", 32'(last_write_cyc() - pulse_cyc), 3);
        wait_pulses("t2_pulse2", 2, 60);
        check("t2_delay2", 32'(pulse_cyc - last_write_cyc()), 17);
        cycles(2);
        check("t2_pc2", pktend_count, 2);
        check_words("t2_data");

        // 100 words with EP-full asserted 3 of every 10 cycles.
        load(16'h1000, 100);
        for (int i = 0; i < 250 && word_count != 32'd618; i++) begin
            @(negedge clk);
            flags_n = {1'b1, (i % 10) < 7, 1'b1};
        end
        flags_n = 3'b111;
        wait_words("t3_wc", 618, 50);
        check_words("t3_data");
        check("t3_no_pop_busy", 32'(viol), 0);
        wait_pulses("t3_pulse", 3, 60);

        // A full packet leaves nothing to commit; disabling with an empty packet is silent.
        load(16'h2000, 256);
        wait_words("t4_wc", 874, 300);
        check_words("t4_data");
        cycles(10000);
        check("t4_no_pulse", 32'(pulse_cnt), 3);
        enable = 1'b0;
        cycles(20);
        check("t4_dis_no_pulse", 32'(pulse_cnt), 3);
        enable = 1'b1;

        // Seven words then disable: one commit, then no pops while idle.
        cycles(5);
        load(16'h3000, 7);
        wait_words("t5_wc", 881, 30);
        enable = 1'b0;
        wait_pulses("t5_pulse", 4, 20);
        cycles(3);
        check("t5_pc", pktend_count, 4);
        load(16'h3100, 3);
        cycles(30);
        check("t5_idle_no_pop", word_count, 881);
        check("t5_single_cycle", 32'(long_pulse), 0);

        // Reset after three words of a packet, then a fresh 253-word packet commits.
        enable = 1'b1;
        wait_words("t6_wc", 884, 20);
        rst_n = 1'b0;
        #1;
        check("t6_slwr", slwr_n, 1);
        check("t6_pktend", pktend_n, 1);
        check("t6_wc0", word_count, 0);
        check("t6_pc0", pktend_count, 0);
        check("t6_data0", usb_data, 0);
        load(16'h4000, 253);
        cycles(3);
        check("t6_no_pop_rst", fifo_rd, 0);
        rst_n = 1'b1;
        wait_words("t6_wc2", 253, 300);
        wait_pulses("t6_pulse", 5, 60);
        check("t6_delay", 32'(pulse_cyc - last_write_cyc()), 17);
        cycles(3);
        check("t6_pc", pktend_count, 1);
        check_words("t6_data");
        check("viol_total", 32'(viol), 0);
        check("long_total", 32'(long_pulse), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
